// File: rtl/uart_pkg.sv
// uart_pkg: state encodings, line levels and baud defaults shared by the UART transmitter and receiver.
package uart_pkg;
    typedef enum logic [4:0] {
        ST_IDLE   = 5'b00001,
        ST_START  = 5'b00010,
        ST_DATA   = 5'b00100,
        ST_STOP   = 5'b01000,
        ST_PARITY = 5'b10000
    } state_t;
    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam int DEF_OVERSAMPLE = 16;
    localparam int DEF_SB_TICK    = 16;
endpackage

// File: rtl/uart_tx.sv
// uart_tx: 8N1 transmitter paced by a 16x baud tick; UART_TX_PARITY_EN inserts an even-parity bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int SIZEDATA   = 8,
    parameter int SB_TICK    = DEF_SB_TICK,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_tick,
    input  logic                i_tx_start,
    input  logic [SIZEDATA-1:0] i_tx_data,
    output logic                o_tx,
    output logic                o_tx_done,
    output logic                o_busy
);
    localparam int CMAX = (SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE;
    localparam int CW = $clog2(CMAX);
    localparam int BW = (SIZEDATA > 1) ? $clog2(SIZEDATA) : 1;
`ifdef UART_TX_PARITY_EN
    localparam state_t AFTER_DATA = ST_PARITY;
    logic par_q, par_n;
`else
    localparam state_t AFTER_DATA = ST_STOP;
`endif
    state_t state_q, state_n;
    logic [CW-1:0] tick_q, tick_n;
    logic [BW-1:0] bit_q, bit_n;
    logic [SIZEDATA-1:0] shift_q, shift_n;
    logic tx_q, tx_n, done_q, done_n, busy_q, busy_n, accept, slot_end;
    always_comb begin
        accept = i_tx_start && !done_q;
        slot_end = i_tick && (tick_q == ((state_q == ST_STOP) ? CW'(SB_TICK - 1) : CW'(OVERSAMPLE - 1)));
        state_n = state_q;
        tick_n = i_tick ? (slot_end ? '0 : tick_q + CW'(1)) : tick_q;
        bit_n = bit_q;
        shift_n = shift_q;
        done_n = 1'b0;
        busy_n = busy_q;
`ifdef UART_TX_PARITY_EN
        par_n = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // the done cycle is still part of the finished frame, so a request there is dropped
                tick_n = '0;
                busy_n = accept;
                if (accept) begin
                    state_n = ST_START;
                    shift_n = i_tx_data;
`ifdef UART_TX_PARITY_EN
                    par_n = ^i_tx_data;
`endif
                end
            end
            ST_START: begin
                if (slot_end) begin
                    bit_n = '0;
                    state_n = ST_DATA;
                end
            end
            ST_DATA: begin
                if (slot_end) begin
                    shift_n = shift_q >> 1;
                    bit_n = (bit_q == BW'(SIZEDATA - 1)) ? bit_q : bit_q + BW'(1);
                    state_n = (bit_q == BW'(SIZEDATA - 1)) ? AFTER_DATA : ST_DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: state_n = slot_end ? ST_STOP : ST_PARITY;
`endif
            ST_STOP: begin
                if (slot_end) begin
                    state_n = ST_IDLE;
                    done_n = 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                tick_n = '0;
                busy_n = 1'b0;
            end
        endcase
        // line level follows the state being entered so o_tx stays a plain register
        tx_n = (state_n == ST_START) ? LINE_START : (state_n == ST_DATA) ? shift_n[0] : LINE_IDLE;
`ifdef UART_TX_PARITY_EN
        if (state_n == ST_PARITY) tx_n = par_n;
`endif
    end
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            tick_q <= '0;
            bit_q <= '0;
            shift_q <= '0;
            tx_q <= LINE_IDLE;
            done_q <= 1'b0;
            busy_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q <= 1'b0;
`endif
        end else begin
            state_q <= state_n;
            tick_q <= tick_n;
            bit_q <= bit_n;
            shift_q <= shift_n;
            tx_q <= tx_n;
            done_q <= done_n;
            busy_q <= busy_n;
`ifdef UART_TX_PARITY_EN
            par_q <= par_n;
`endif
        end
    end
    assign o_tx = tx_q;
    assign o_tx_done = done_q;
    assign o_busy = busy_q;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized frame checks of uart_tx against a slot-level line model; honours UART_TX_PARITY_EN.
module tb_uart_tx;
    localparam int OS = 16;
    localparam int SB = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NS = 11;
`else
    localparam int NS = 10;
`endif
    localparam int TOTAL = (NS - 1) * OS + SB;
    logic i_clock = 1'b0;
    logic i_reset, i_tick, i_tx_start;
    logic [7:0] i_tx_data;
    logic o_tx, o_tx_done, o_busy;
    int n_checks = 0;
    int n_fails = 0;
    int ph = 0;
    int stall_left = 0;
    uart_tx dut (
        .i_clock(i_clock),
        .i_reset(i_reset),
        .i_tick(i_tick),
        .i_tx_start(i_tx_start),
        .i_tx_data(i_tx_data),
        .o_tx(o_tx),
        .o_tx_done(o_tx_done),
        .o_busy(o_busy)
    );
    always #5 i_clock = ~i_clock;
    // expected line level for each 16-tick slot: start, 8 data bits LSB first, optional even parity, stop
    function automatic logic [15:0] exp_slots(input logic [7:0] b);
        logic [15:0] s;
        int ones;
        s = '0;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            s[i+1] = ((b >> i) & 8'd1) != 8'd0;
            ones += int'((b >> i) & 8'd1);
        end
`ifdef UART_TX_PARITY_EN
        s[9] = (ones % 2) == 1;
`endif
        s[NS-1] = 1'b1;
        return s;
    endfunction
    task automatic step();
        @(posedge i_clock);
        #1;
        ph = (ph + 1) % 4;
        if (stall_left > 0) stall_left--;
        i_tick = (ph == 0) && (stall_left == 0);
    endtask
    task automatic send(input logic [7:0] b, input bit hold);
        int w;
        w = 0;
        step();
        while (i_tick !== 1'b1 && w < 20) begin
            step();
            w++;
        end
        i_tx_start = 1'b1;
        i_tx_data = b;
        step();
        if (!hold) i_tx_start = 1'b0;
    endtask
    // follows one frame from the observation just after acceptance; k counts ticks since acceptance
    task automatic capture(input logic [15:0] exp, input int inj_k, input logic [7:0] inj_d,
                           input int stall_k, input int rst_k,
                           output logic [15:0] slots, output int done_cnt, output int done_k,
                           output int done_j, output int busy_bad, output int line_bad,
                           output int stall_chg, output bit aborted);
        int k, j;
        bit t, inj_on, rst_on;
        logic held, e;
        k = 0; j = 0; inj_on = 0; rst_on = 0; held = 1'b1;
        slots = '0; done_cnt = 0; done_k = -1; done_j = -1;
        busy_bad = 0; line_bad = 0; stall_chg = 0; aborted = 0;
        while (done_cnt == 0 && !aborted && j < 6000) begin
            t = (i_tick === 1'b1);
            step();
            j++;
            if (inj_on) begin
                i_tx_start = 1'b0;
                inj_on = 0;
            end
            if (rst_on) aborted = 1;
            else begin
                if (t) k++;
                e = (k >= TOTAL) ? 1'b1 : exp[k/OS];
                if (o_tx !== e) line_bad++;
                if (o_busy !== 1'b1) busy_bad++;
                if (o_tx_done === 1'b1) begin
                    done_cnt++;
                    done_k = k;
                    done_j = j;
                end
                if (t && k % OS == OS / 2) slots[k/OS] = o_tx;
                if (stall_left > 0 && o_tx !== held) stall_chg++;
                if (t && k == stall_k) begin
                    stall_left = 100;
                    held = o_tx;
                    i_tick = 1'b0;
                end
                if (t && k == inj_k) begin
                    i_tx_start = 1'b1;
                    i_tx_data = inj_d;
                    inj_on = 1;
                end
                if (t && k == rst_k) begin
                    i_reset = 1'b1;
                    rst_on = 1;
                end
            end
        end
    endtask
    task automatic test_reset();
        i_reset = 1'b1;
        repeat (3) step();
        n_checks++; if (o_tx !== 1'b1) begin n_fails++; $display("FAIL reset_tx: got %b expected 1", o_tx); end
        n_checks++; if (o_tx_done !== 1'b0) begin n_fails++; $display("FAIL reset_done: got %b expected 0", o_tx_done); end
        n_checks++; if (o_busy !== 1'b0) begin n_fails++; $display("FAIL reset_busy: got %b expected 0", o_busy); end
        i_reset = 1'b0;
        step();
    endtask
    task automatic test_send();
        logic [15:0] sl; int dc, dk, dj, bb, lb, sc; bit ab;
        send(8'hA5, 0);
        n_checks++; if (o_tx !== 1'b0 || o_busy !== 1'b1) begin n_fails++; $display("FAIL send_accept: got tx=%b busy=%b expected tx=0 busy=1", o_tx, o_busy); end
        capture(exp_slots(8'hA5), -1, 8'h00, -1, -1, sl, dc, dk, dj, bb, lb, sc, ab);
        n_checks++; if (sl !== exp_slots(8'hA5)) begin n_fails++; $display("FAIL send_slots: got %b expected %b", sl, exp_slots(8'hA5)); end
        n_checks++; if (lb != 0) begin n_fails++; $display("FAIL send_line: got %0d bad cycles expected 0", lb); end
        n_checks++; if (dc != 1) begin n_fails++; $display("FAIL send_done_count: got %0d expected 1", dc); end
        n_checks++; if (dj != TOTAL * 4) begin n_fails++; $display("FAIL send_done_clocks: got %0d expected %0d", dj, TOTAL * 4); end
        n_checks++; if (bb != 0) begin n_fails++; $display("FAIL send_busy: got %0d low cycles expected 0", bb); end
        step();
        n_checks++; if (o_tx_done !== 1'b0 || o_busy !== 1'b0) begin n_fails++; $display("FAIL send_after: got done=%b busy=%b expected 0 0", o_tx_done, o_busy); end
    endtask
    task automatic test_busy_reject();
        logic [15:0] sl; int dc, dk, dj, bb, lb, sc, extra, low; bit ab;
        send(8'h3C, 0);
        capture(exp_slots(8'h3C), 40, 8'hFF, -1, -1, sl, dc, dk, dj, bb, lb, sc, ab);
        n_checks++; if (sl !== exp_slots(8'h3C)) begin n_fails++; $display("FAIL reject_slots: got %b expected %b", sl, exp_slots(8'h3C)); end
        n_checks++; if (lb != 0) begin n_fails++; $display("FAIL reject_line: got %0d bad cycles expected 0", lb); end
        n_checks++; if (dk != TOTAL) begin n_fails++; $display("FAIL reject_done_tick: got %0d expected %0d", dk, TOTAL); end
        extra = 0; low = 0;
        repeat (200) begin
            step();
            if (o_tx_done === 1'b1) extra++;
            if (o_tx !== 1'b1) low++;
        end
        n_checks++; if (extra != 0) begin n_fails++; $display("FAIL reject_extra_done: got %0d expected 0", extra); end
        n_checks++; if (low != 0) begin n_fails++; $display("FAIL reject_line_idle: got %0d low cycles expected 0", low); end
    endtask
    task automatic test_back_to_back();
        logic [15:0] sl; int dc, dk, dj, bb, lb, sc; bit ab;
        send(8'h55, 1);
        i_tx_data = 8'h0F;
        capture(exp_slots(8'h55), -1, 8'h00, -1, -1, sl, dc, dk, dj, bb, lb, sc, ab);
        n_checks++; if (sl !== exp_slots(8'h55)) begin n_fails++; $display("FAIL b2b_first_slots: got %b expected %b", sl, exp_slots(8'h55)); end
        n_checks++; if (dk != TOTAL || lb != 0) begin n_fails++; $display("FAIL b2b_first_frame: got done_tick=%0d bad=%0d expected %0d 0", dk, lb, TOTAL); end
        step();
        n_checks++; if (o_tx !== 1'b1 || o_busy !== 1'b0) begin n_fails++; $display("FAIL b2b_gap: got tx=%b busy=%b expected 1 0", o_tx, o_busy); end
        step();
        n_checks++; if (o_tx !== 1'b0 || o_busy !== 1'b1) begin n_fails++; $display("FAIL b2b_restart: got tx=%b busy=%b expected 0 1", o_tx, o_busy); end
        i_tx_start = 1'b0;
        capture(exp_slots(8'h0F), -1, 8'h00, -1, -1, sl, dc, dk, dj, bb, lb, sc, ab);
        n_checks++; if (sl !== exp_slots(8'h0F)) begin n_fails++; $display("FAIL b2b_second_slots: got %b expected %b", sl, exp_slots(8'h0F)); end
        n_checks++; if (dk != TOTAL || lb != 0) begin n_fails++; $display("FAIL b2b_second_frame: got done_tick=%0d bad=%0d expected %0d 0", dk, lb, TOTAL); end
    endtask
    task automatic test_reset_mid();
        logic [15:0] sl; int dc, dk, dj, bb, lb, sc, extra, busy_hi; bit ab;
        send(8'h81, 0);
        capture(exp_slots(8'h81), -1, 8'h00, -1, 4 * OS + 8, sl, dc, dk, dj, bb, lb, sc, ab);
        n_checks++; if (o_tx !== 1'b1 || o_busy !== 1'b0) begin n_fails++; $display("FAIL rst_mid_state: got tx=%b busy=%b expected 1 0", o_tx, o_busy); end
        n_checks++; if (o_tx_done !== 1'b0 || dc != 0) begin n_fails++; $display("FAIL rst_mid_done: got done=%b count=%0d expected 0 0", o_tx_done, dc); end
        i_reset = 1'b0;
        extra = 0; busy_hi = 0;
        repeat (120) begin
            step();
            if (o_tx_done === 1'b1) extra++;
            if (o_busy !== 1'b0) busy_hi++;
        end
        n_checks++; if (extra != 0 || busy_hi != 0) begin n_fails++; $display("FAIL rst_mid_quiet: got done=%0d busy=%0d expected 0 0", extra, busy_hi); end
        send(8'h81, 0);
        capture(exp_slots(8'h81), -1, 8'h00, -1, -1, sl, dc, dk, dj, bb, lb, sc, ab);
        n_checks++; if (sl !== exp_slots(8'h81) || lb != 0) begin n_fails++; $display("FAIL rst_resend: got %b bad=%0d expected %b 0", sl, lb, exp_slots(8'h81)); end
        n_checks++; if (dc != 1 || dk != TOTAL) begin n_fails++; $display("FAIL rst_resend_done: got count=%0d tick=%0d expected 1 %0d", dc, dk, TOTAL); end
    endtask
    task automatic test_stall();
        logic [15:0] sl; int dc, dk, dj, bb, lb, sc; bit ab;
        send(8'hC6, 0);
        capture(exp_slots(8'hC6), -1, 8'h00, 3 * OS + 4, -1, sl, dc, dk, dj, bb, lb, sc, ab);
        n_checks++; if (sc != 0) begin n_fails++; $display("FAIL stall_hold: got %0d changes expected 0", sc); end
        n_checks++; if (sl !== exp_slots(8'hC6) || lb != 0) begin n_fails++; $display("FAIL stall_slots: got %b bad=%0d expected %b 0", sl, lb, exp_slots(8'hC6)); end
        n_checks++; if (dk != TOTAL || dj <= TOTAL * 4) begin n_fails++; $display("FAIL stall_done: got tick=%0d clocks=%0d expected %0d and >%0d", dk, dj, TOTAL, TOTAL * 4); end
    endtask
    task automatic test_random();
        logic [15:0] sl; int dc, dk, dj, bb, lb, sc; bit ab;
        logic [7:0] b;
        for (int n = 0; n < 5; n++) begin
            b = 8'($urandom);
            repeat ($urandom_range(0, 12)) step();
            send(b, 0);
            capture(exp_slots(b), -1, 8'h00, -1, -1, sl, dc, dk, dj, bb, lb, sc, ab);
            n_checks++; if (sl !== exp_slots(b) || lb != 0) begin n_fails++; $display("FAIL random_%0h_slots: got %b bad=%0d expected %b 0", b, sl, lb, exp_slots(b)); end
            n_checks++; if (dc != 1 || dk != TOTAL || bb != 0) begin n_fails++; $display("FAIL random_%0h_done: got count=%0d tick=%0d busy_low=%0d expected 1 %0d 0", b, dc, dk, bb, TOTAL); end
        end
    endtask
`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [15:0] sl; int dc, dk, dj, bb, lb, sc; bit ab;
        send(8'h07, 0);
        capture(exp_slots(8'h07), -1, 8'h00, -1, -1, sl, dc, dk, dj, bb, lb, sc, ab);
        n_checks++; if (sl[9] !== 1'b1 || lb != 0) begin n_fails++; $display("FAIL parity_07: got %b bad=%0d expected 1 0", sl[9], lb); end
        n_checks++; if (dk != 176 || dj != 704) begin n_fails++; $display("FAIL parity_len: got tick=%0d clocks=%0d expected 176 704", dk, dj); end
        send(8'h03, 0);
        capture(exp_slots(8'h03), -1, 8'h00, -1, -1, sl, dc, dk, dj, bb, lb, sc, ab);
        n_checks++; if (sl[9] !== 1'b0 || lb != 0) begin n_fails++; $display("FAIL parity_03: got %b bad=%0d expected 0 0", sl[9], lb); end
    endtask
`endif
    initial begin
        i_reset = 1'b1;
        i_tick = 1'b0;
        i_tx_start = 1'b0;
        i_tx_data = 8'h00;
        test_reset();
        test_send();
        test_busy_reject();
        test_back_to_back();
        test_reset_mid();
        test_stall();
        test_random();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fails);
        $fatal(1, "watchdog expired");
    end
endmodule
